// File: rtl/ase_session_ctrl.sv
// ASE session lifecycle controller: latches run config, gates AFU reset,
// counts completed sessions and decides when to request simulation kill.
module ase_session_ctrl #(
  parameter int DRAIN_CYCLES = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_num_tests,
  input  logic             session_start,
  input  logic             session_end,
  input  logic             activity,
  input  logic             sw_kill_req,
  output logic             afu_reset_n,
  output logic             sim_kill,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] test_count,
  output logic             timeout_fire,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    KILL  = 3'd4
  } state_t;

  localparam logic [2:0] M_DAEMON  = 3'd1;
  localparam logic [2:0] M_TMO     = 3'd2;
  localparam logic [2:0] M_SW      = 3'd3;
  localparam logic [2:0] M_REGRESS = 3'd4;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t           st, st_nxt;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] timeout_q, num_tests_q, idle_cnt;
  logic [DW-1:0]    drain_cnt;

  logic             mode_legal, cfg_open, kill_en, in_rr;
  logic             sw_kill, tmo_hit, drain_done, complete;
  logic [2:0]       mode_eff;
  logic [CNT_W-1:0] cnt_inc;

  assign mode_legal = (cfg_mode >= M_DAEMON) && (cfg_mode <= M_REGRESS);
  assign mode_eff   = mode_legal ? cfg_mode : M_DAEMON;
  assign cfg_open   = (st == IDLE) || (st == READY);
  assign in_rr      = (st == READY) || (st == RUN);
  assign kill_en    = (mode_q == M_SW) || (mode_q == M_REGRESS);

  assign sw_kill    = sw_kill_req && kill_en && (in_rr || (st == DRAIN));
  assign tmo_hit    = (mode_q == M_TMO) && (timeout_q != '0) && !activity &&
                      in_rr && (idle_cnt == timeout_q - 1'b1);
  assign drain_done = (st == DRAIN) && !activity && (drain_cnt == DRAIN_LAST);
  assign cnt_inc    = (&test_count) ? test_count : test_count + 1'b1;

  // Priority inside a cycle: sw kill, then timeout, then end, then start.
  always_comb begin
    st_nxt   = st;
    complete = 1'b0;
    case (st)
      IDLE:  if (cfg_valid) st_nxt = READY;
      READY: begin
        if (sw_kill || tmo_hit) st_nxt = KILL;
        else if (session_start) st_nxt = RUN;
      end
      RUN: begin
        if (sw_kill || tmo_hit) st_nxt = KILL;
        else if (session_end)   st_nxt = DRAIN;
      end
      DRAIN: begin
        if (sw_kill) st_nxt = KILL;
        else if (drain_done) begin
          complete = 1'b1;
          case (mode_q)
            M_SW:      st_nxt = KILL;
            M_REGRESS: st_nxt = (cnt_inc >= num_tests_q) ? KILL : READY;
            default:   st_nxt = READY;
          endcase
        end
      end
      KILL:    st_nxt = KILL;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      afu_reset_n  <= 1'b0;
      sim_kill     <= 1'b0;
      timeout_fire <= 1'b0;
      cfg_err      <= 1'b0;
      test_count   <= '0;
    end else begin
      st           <= st_nxt;
      afu_reset_n  <= (st_nxt == RUN);
      sim_kill     <= (st_nxt == KILL);
      timeout_fire <= tmo_hit && !sw_kill;
      if (cfg_valid && (!cfg_open || !mode_legal)) cfg_err <= 1'b1;
      if (complete) test_count <= cnt_inc;
    end
  end

  // Config is only accepted while no session is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= '0;
      timeout_q   <= '0;
      num_tests_q <= '0;
    end else if (cfg_valid && cfg_open) begin
      mode_q      <= mode_eff;
      timeout_q   <= cfg_timeout;
      num_tests_q <= (cfg_num_tests == '0) ? CNT_W'(1) : cfg_num_tests;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!in_rr || (st_nxt != st) || activity || session_start) begin
      idle_cnt <= '0;
    end else if (!(&idle_cnt)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if ((st != DRAIN) || activity || (drain_cnt == DRAIN_LAST)) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_ase_session_ctrl.sv
// Directed bench for ase_session_ctrl with DRAIN_CYCLES=4.
module tb_ase_session_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic [2:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_timeout, cfg_num_tests;
  logic             session_start, session_end, activity, sw_kill_req;
  logic             afu_reset_n, sim_kill, timeout_fire, cfg_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] test_count;

  int total = 0;
  int bad   = 0;

  ase_session_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_timeout(cfg_timeout),
    .cfg_num_tests(cfg_num_tests), .session_start(session_start),
    .session_end(session_end), .activity(activity), .sw_kill_req(sw_kill_req),
    .afu_reset_n(afu_reset_n), .sim_kill(sim_kill), .state(state),
    .test_count(test_count), .timeout_fire(timeout_fire), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] m, input int tmo, input int n);
    cfg_valid = 1'b1; cfg_mode = m; cfg_timeout = tmo; cfg_num_tests = n;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_s();
    session_start = 1'b1; tick(); session_start = 1'b0;
  endtask

  task automatic end_s();
    session_end = 1'b1; tick(); session_end = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear before the next clock edge.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_state"}, state, 0);
    chk({tag, "_afu"}, afu_reset_n, 0);
    chk({tag, "_kill"}, sim_kill, 0);
    chk({tag, "_cnt"}, test_count, 0);
    chk({tag, "_err"}, cfg_err, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_timeout = '0;
    cfg_num_tests = '0; session_start = 1'b0; session_end = 1'b0;
    activity = 1'b0; sw_kill_req = 1'b0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_afu", afu_reset_n, 0);
    chk("rst_kill", sim_kill, 0);
    chk("rst_cnt", test_count, 0);
    chk("rst_tfire", timeout_fire, 0);
    chk("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();

    // DAEMON: three full sessions, never kills
    cfg(3'd1, 0, 0);
    chk("dmn_ready", state, 1);
    chk("dmn_err", cfg_err, 0);
    for (int i = 0; i < 3; i++) begin
      start_s();
      chk("dmn_run", state, 2);
      chk("dmn_afu_run", afu_reset_n, 1);
      end_s();
      chk("dmn_drain", state, 3);
      chk("dmn_afu_drain", afu_reset_n, 0);
      repeat (3) tick();
      chk("dmn_drain3", state, 3);
      tick();
      chk("dmn_done", state, 1);
      chk("dmn_cnt", test_count, i + 1);
      chk("dmn_kill", sim_kill, 0);
    end

    // TIMEOUT_SIMKILL re-latched from READY, timeout=10
    cfg(3'd2, 10, 0);
    start_s();
    chk("tmo_run", state, 2);
    repeat (4) tick();
    activity = 1'b1; tick(); activity = 1'b0;
    repeat (9) tick();
    chk("tmo_early_fire", timeout_fire, 0);
    chk("tmo_early_state", state, 2);
    tick();
    chk("tmo_fire", timeout_fire, 1);
    chk("tmo_kill_state", state, 4);
    chk("tmo_kill", sim_kill, 1);
    chk("tmo_afu", afu_reset_n, 0);
    tick();
    chk("tmo_fire_pulse", timeout_fire, 0);
    chk("tmo_kill_sticky", sim_kill, 1);
    chk("tmo_state_sticky", state, 4);
    async_reset("rstkill");

    // REGRESSION, 2 tests, activity on drain cycle 2 of the first session
    cfg(3'd4, 0, 2);
    start_s();
    end_s();
    tick(); tick();
    activity = 1'b1; tick(); activity = 1'b0;
    repeat (3) tick();
    chk("reg_drain_long", state, 3);
    tick();
    chk("reg_first_done", state, 1);
    chk("reg_cnt1", test_count, 1);
    start_s();
    end_s();
    repeat (4) tick();
    chk("reg_kill_state", state, 4);
    chk("reg_cnt2", test_count, 2);
    chk("reg_kill", sim_kill, 1);
    async_reset("rst2");

    // SW_SIMKILL: kill beats same-cycle end
    cfg(3'd3, 0, 0);
    start_s();
    sw_kill_req = 1'b1; session_end = 1'b1; tick();
    sw_kill_req = 1'b0; session_end = 1'b0;
    chk("sw_kill_state", state, 4);
    chk("sw_kill_cnt", test_count, 0);
    chk("sw_kill", sim_kill, 1);
    async_reset("rst3");

    // DAEMON ignores sw_kill_req
    cfg(3'd1, 0, 0);
    start_s();
    sw_kill_req = 1'b1; session_end = 1'b1; tick();
    sw_kill_req = 1'b0; session_end = 1'b0;
    chk("dsw_drain", state, 3);
    repeat (4) tick();
    chk("dsw_ready", state, 1);
    chk("dsw_cnt", test_count, 1);
    chk("dsw_kill", sim_kill, 0);
    async_reset("rst4");

    // Illegal mode 6 behaves as DAEMON; cfg in RUN ignored
    cfg(3'd6, 0, 0);
    chk("ill_state", state, 1);
    chk("ill_err", cfg_err, 1);
    start_s();
    end_s();
    repeat (4) tick();
    chk("ill_done", state, 1);
    chk("ill_cnt", test_count, 1);
    start_s();
    cfg(3'd2, 3, 0);
    chk("runcfg_state", state, 2);
    chk("runcfg_err", cfg_err, 1);
    repeat (5) tick();
    chk("runcfg_no_tmo", state, 2);
    chk("runcfg_no_fire", timeout_fire, 0);

    // Reset mid-DRAIN, then a fresh session
    end_s();
    tick();
    chk("mid_drain", state, 3);
    async_reset("rstdrain");
    cfg(3'd1, 0, 0);
    start_s();
    end_s();
    repeat (4) tick();
    chk("post_rst_state", state, 1);
    chk("post_rst_cnt", test_count, 1);
    chk("post_rst_err", cfg_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
